// File: rtl/pipe_pkg.sv
// Shared pipeline types: access-type and writeback-select encodings,
// MEM-stage FSM states, the latched request bundle and alignment helpers.
package pipe_pkg;

  typedef enum logic [2:0] {
    DM_B  = 3'b000,
    DM_H  = 3'b001,
    DM_W  = 3'b010,
    DM_BU = 3'b011,
    DM_HU = 3'b100
  } dmtype_e;

  typedef enum logic [1:0] {
    WD_ALU = 2'b00,
    WD_MEM = 2'b01,
    WD_PC4 = 2'b10
  } wdsel_e;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] alu_result;
    logic [31:0] wdata;
    logic [2:0]  dmtype;
    logic        we;
    logic        ld;
    logic [4:0]  rd;
    logic        reg_write;
    logic [1:0]  wdsel;
  } mem_req_t;

  // Low address bits after forcing natural alignment.
  function automatic logic [1:0] align_lo(
    input logic [2:0] dm,
    input logic [1:0] a
  );
    if (dm == DM_W)
      return 2'b00;
    if (dm == DM_H || dm == DM_HU)
      return {a[1], 1'b0};
    return a;
  endfunction

  // True when a halfword/word access is not naturally aligned.
  function automatic logic misaligned(
    input logic [2:0] dm,
    input logic [1:0] a
  );
    return ((dm == DM_H || dm == DM_HU) && a[0])
        || ((dm == DM_W) && (a != 2'b00));
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/response bus between the MEM stage
// (master) and the data memory (slave).
interface mem_stage_if #(
  parameter int ADDR_W = 32
);
  logic              dmem_req;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [31:0]       dmem_wdata;
  logic [3:0]        dmem_be;
  logic [31:0]       dmem_rdata;
  logic              dmem_ready;

  modport master (
    output dmem_req,
    output dmem_we,
    output dmem_addr,
    output dmem_wdata,
    output dmem_be,
    input  dmem_rdata,
    input  dmem_ready
  );

  modport slave (
    input  dmem_req,
    input  dmem_we,
    input  dmem_addr,
    input  dmem_wdata,
    input  dmem_be,
    output dmem_rdata,
    output dmem_ready
  );
endinterface

// File: rtl/mem_align.sv
// Byte-lane logic: byte enables, store replication,
// load lane select and sign/zero extension.
module mem_align
  import pipe_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  dmtype,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [31:0] shifted;

  assign shifted = rdata >> {addr_lo, 3'b000};

  // Decode access type into lane enables and data shaping.
  always_comb begin
    be        = 4'b1111;
    wdata     = store_data;
    load_data = rdata;
    unique case (1'b1)
      (dmtype == DM_B): begin
        be        = 4'b0001 << addr_lo;
        wdata     = {4{store_data[7:0]}};
        load_data = {{24{shifted[7]}}, shifted[7:0]};
      end
      (dmtype == DM_BU): begin
        be        = 4'b0001 << addr_lo;
        wdata     = {4{store_data[7:0]}};
        load_data = {24'h0, shifted[7:0]};
      end
      (dmtype == DM_H): begin
        be        = 4'b0011 << addr_lo;
        wdata     = {2{store_data[15:0]}};
        load_data = {{16{shifted[15]}}, shifted[15:0]};
      end
      (dmtype == DM_HU): begin
        be        = 4'b0011 << addr_lo;
        wdata     = {2{store_data[15:0]}};
        load_data = {16'h0, shifted[15:0]};
      end
      default: begin
        be        = 4'b1111;
        wdata     = store_data;
        load_data = rdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: data-memory access FSM plus MEM/WB register.
// Optional MEM_MISALIGN_TRAP_EN traps misaligned H/W instead of aligning.
module mem_stage
  import pipe_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        valid_in,
  input  logic [31:0] ALU_result_in,
  input  logic [31:0] ALU_B_in,
  input  logic        MemRead_in,
  input  logic        MemWrite_in,
  input  logic [2:0]  DMType_in,
  input  logic [4:0]  rd_in,
  input  logic        RegWrite_in,
  input  logic [1:0]  WDSel_in,
  mem_stage_if.master dmem,
  output logic        stall_out,
  output logic        valid_out,
  output logic [4:0]  rd_out,
  output logic        RegWrite_out,
  output logic [1:0]  WDSel_out,
  output logic [31:0] ALU_result_out,
  output logic [31:0] load_data_out,
  output logic        misalign_exc
);

  state_e      state;
  mem_req_t    lat;
  mem_req_t    nxt;
  mem_req_t    cur;
  logic        is_mem;
  logic        busy;
  logic        accept;
  logic        acc_mem;
  logic        trap;
  logic        start;
  logic        req_now;
  logic        done;
  logic        fire;
  logic [31:0] addr_n;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] ld_ext;

  assign is_mem  = MemRead_in | MemWrite_in;
  assign busy    = (state == ACCESS);
  assign accept  = valid_in & ~busy;
  assign acc_mem = accept & is_mem;

`ifdef MEM_MISALIGN_TRAP_EN
  assign trap   = acc_mem
                & misaligned(DMType_in, ALU_result_in[1:0]);
  assign addr_n = ALU_result_in;
`else
  assign trap   = 1'b0;
  assign addr_n = {ALU_result_in[31:2],
                   align_lo(DMType_in, ALU_result_in[1:0])};
`endif

  assign start   = acc_mem & ~trap;
  assign req_now = rstn & (start | busy);
  assign done    = req_now & dmem.dmem_ready;
  assign fire    = done | (accept & ~start);

  // A store never writes back, even if MemRead is also set.
  assign nxt = '{
    addr:       addr_n,
    alu_result: ALU_result_in,
    wdata:      ALU_B_in,
    dmtype:     DMType_in,
    we:         MemWrite_in,
    ld:         MemRead_in & ~MemWrite_in,
    rd:         rd_in,
    reg_write:  RegWrite_in & ~MemWrite_in,
    wdsel:      WDSel_in
  };

  assign cur = busy ? lat : nxt;

  mem_align u_align (
    .addr_lo    (cur.addr[1:0]),
    .dmtype     (cur.dmtype),
    .store_data (cur.wdata),
    .rdata      (dmem.dmem_rdata),
    .be         (be),
    .wdata      (wdata),
    .load_data  (ld_ext)
  );

  assign dmem.dmem_req   = req_now;
  assign dmem.dmem_we    = req_now & cur.we;
  assign dmem.dmem_addr  = req_now ? cur.addr[ADDR_W-1:0] : '0;
  assign dmem.dmem_wdata = req_now ? wdata : '0;
  assign dmem.dmem_be    = req_now ? be : '0;
  assign stall_out       = req_now;

  // Access FSM, request latch and registered MEM/WB fields.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state          <= IDLE;
      lat            <= '0;
      valid_out      <= 1'b0;
      rd_out         <= '0;
      RegWrite_out   <= 1'b0;
      WDSel_out      <= '0;
      ALU_result_out <= '0;
      load_data_out  <= '0;
      misalign_exc   <= 1'b0;
    end else begin
      valid_out    <= fire;
      RegWrite_out <= fire & cur.reg_write & ~trap;
      misalign_exc <= trap;
      if (fire) begin
        rd_out         <= cur.rd;
        WDSel_out      <= cur.wdsel;
        ALU_result_out <= cur.alu_result;
        load_data_out  <= (cur.ld & ~trap) ? ld_ext : '0;
      end
      unique case (state)
        ACCESS: begin
          if (dmem.dmem_ready)
            state <= RESP;
        end
        default: begin
          state <= IDLE;
          if (start) begin
            lat   <= nxt;
            state <= dmem.dmem_ready ? RESP : ACCESS;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: expected MEM/WB outputs go to a queue,
// a negedge monitor pops and compares on every valid_out.
module tb_mem_stage;
  import pipe_pkg::*;

  logic        clk;
  logic        rstn;
  logic        valid_in;
  logic [31:0] ALU_result_in;
  logic [31:0] ALU_B_in;
  logic        MemRead_in;
  logic        MemWrite_in;
  logic [2:0]  DMType_in;
  logic [4:0]  rd_in;
  logic        RegWrite_in;
  logic [1:0]  WDSel_in;
  logic        stall_out;
  logic        valid_out;
  logic [4:0]  rd_out;
  logic        RegWrite_out;
  logic [1:0]  WDSel_out;
  logic [31:0] ALU_result_out;
  logic [31:0] load_data_out;
  logic        misalign_exc;

  mem_stage_if #(.ADDR_W(32)) dmem ();

  mem_stage #(.ADDR_W(32)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .valid_in       (valid_in),
    .ALU_result_in  (ALU_result_in),
    .ALU_B_in       (ALU_B_in),
    .MemRead_in     (MemRead_in),
    .MemWrite_in    (MemWrite_in),
    .DMType_in      (DMType_in),
    .rd_in          (rd_in),
    .RegWrite_in    (RegWrite_in),
    .WDSel_in       (WDSel_in),
    .dmem           (dmem),
    .stall_out      (stall_out),
    .valid_out      (valid_out),
    .rd_out         (rd_out),
    .RegWrite_out   (RegWrite_out),
    .WDSel_out      (WDSel_out),
    .ALU_result_out (ALU_result_out),
    .load_data_out  (load_data_out),
    .misalign_exc   (misalign_exc)
  );

  typedef struct {
    logic [4:0]  rd;
    logic        rw;
    logic [1:0]  wd;
    logic [31:0] alu;
    logic [31:0] ld;
    logic        mis;
  } exp_t;

  exp_t q[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   nst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total_cnt++;
    if (act === exp)
      pass_cnt++;
    else
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic expect_out(input logic [4:0] rd,
                            input logic rw,
                            input logic [1:0] wd,
                            input logic [31:0] alu,
                            input logic [31:0] ld,
                            input logic mis);
    exp_t e;
    e = '{rd: rd, rw: rw, wd: wd, alu: alu, ld: ld, mis: mis};
    q.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    valid_in        = 1'b0;
    MemRead_in      = 1'b0;
    MemWrite_in     = 1'b0;
    dmem.dmem_ready = 1'b0;
  endtask

  task automatic issue(input logic [4:0] rd,
                       input logic rw,
                       input logic [1:0] wd,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input logic mr,
                       input logic mw,
                       input logic [2:0] dm);
    valid_in      = 1'b1;
    rd_in         = rd;
    RegWrite_in   = rw;
    WDSel_in      = wd;
    ALU_result_in = a;
    ALU_B_in      = b;
    MemRead_in    = mr;
    MemWrite_in   = mw;
    DMType_in     = dm;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rstn && valid_out) begin
      if (q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_valid: got valid_out=1 expected none");
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("out_rd", {27'h0, rd_out}, {27'h0, e.rd});
        chk("out_regwrite", {31'h0, RegWrite_out}, {31'h0, e.rw});
        chk("out_wdsel", {30'h0, WDSel_out}, {30'h0, e.wd});
        chk("out_alu", ALU_result_out, e.alu);
        chk("out_load", load_data_out, e.ld);
        chk("out_misalign", {31'h0, misalign_exc}, {31'h0, e.mis});
      end
    end
  end

  initial begin
    rstn            = 1'b0;
    dmem.dmem_rdata = 32'h0;
    rd_in           = '0;
    RegWrite_in     = 1'b0;
    WDSel_in        = '0;
    ALU_result_in   = '0;
    ALU_B_in        = '0;
    DMType_in       = '0;
    idle();

    // reset state
    @(negedge clk);
    chk("rst_valid", {31'h0, valid_out}, 32'h0);
    chk("rst_req", {31'h0, dmem.dmem_req}, 32'h0);
    chk("rst_stall", {31'h0, stall_out}, 32'h0);
    chk("rst_regwrite", {31'h0, RegWrite_out}, 32'h0);
    chk("rst_load", load_data_out, 32'h0);
    chk("rst_misalign", {31'h0, misalign_exc}, 32'h0);
    #2 rstn = 1'b1;

    // ALU pass-through, latency 1
    cyc();
    issue(5'd5, 1'b1, WD_ALU, 32'h1234, 32'h0, 1'b0, 1'b0, DM_W);
    expect_out(5'd5, 1'b1, WD_ALU, 32'h1234, 32'h0, 1'b0);
    @(negedge clk);
    chk("alu_stall", {31'h0, stall_out}, 32'h0);
    chk("alu_req", {31'h0, dmem.dmem_req}, 32'h0);
    cyc();
    idle();
    dmem.dmem_ready = 1'b1;
    @(negedge clk);
    chk("alu_lat", {31'h0, valid_out}, 32'h1);
    chk("stray_ready_stall", {31'h0, stall_out}, 32'h0);
    chk("stray_ready_req", {31'h0, dmem.dmem_req}, 32'h0);
    cyc();
    dmem.dmem_ready = 1'b0;
    @(negedge clk);
    chk("idle_valid", {31'h0, valid_out}, 32'h0);
    chk("idle_regwrite", {31'h0, RegWrite_out}, 32'h0);

    // LB 0x103, ready on third request cycle
    cyc();
    issue(5'd7, 1'b1, WD_MEM, 32'h103, 32'h0, 1'b1, 1'b0, DM_B);
    dmem.dmem_rdata = 32'h80FF_FF7F;
    expect_out(5'd7, 1'b1, WD_MEM, 32'h103, 32'hFFFF_FF80, 1'b0);
    nst = 0;
    for (int k = 0; k < 3; k++) begin
      if (k == 2) dmem.dmem_ready = 1'b1;
      @(negedge clk);
      if (stall_out) nst++;
      chk("lb_addr", dmem.dmem_addr, 32'h103);
      chk("lb_be", {28'h0, dmem.dmem_be}, 32'h8);
      cyc();
      if (k == 0) begin
        ALU_result_in = 32'h0000_0DEA;
        DMType_in     = DM_W;
      end
    end
    idle();
    @(negedge clk);
    chk("lb_valid", {31'h0, valid_out}, 32'h1);
    chk("lb_stall_after", {31'h0, stall_out}, 32'h0);
    chk("lb_stall_cycles", nst, 32'd3);

    // SH 0x102, ready same cycle
    cyc();
    issue(5'd9, 1'b1, WD_ALU, 32'h102, 32'h0000_BEEF, 1'b0, 1'b1, DM_H);
    dmem.dmem_ready = 1'b1;
    expect_out(5'd9, 1'b0, WD_ALU, 32'h102, 32'h0, 1'b0);
    @(negedge clk);
    chk("sh_req", {31'h0, dmem.dmem_req}, 32'h1);
    chk("sh_we", {31'h0, dmem.dmem_we}, 32'h1);
    chk("sh_be", {28'h0, dmem.dmem_be}, 32'hC);
    chk("sh_wdata", dmem.dmem_wdata, 32'hBEEF_BEEF);
    chk("sh_stall", {31'h0, stall_out}, 32'h1);
    cyc();
    idle();
    @(negedge clk);
    chk("sh_valid", {31'h0, valid_out}, 32'h1);

    // SB 0x101, byte replication
    cyc();
    issue(5'd4, 1'b1, WD_ALU, 32'h101, 32'h1234_5678, 1'b0, 1'b1, DM_B);
    dmem.dmem_ready = 1'b1;
    expect_out(5'd4, 1'b0, WD_ALU, 32'h101, 32'h0, 1'b0);
    @(negedge clk);
    chk("sb_be", {28'h0, dmem.dmem_be}, 32'h2);
    chk("sb_wdata", dmem.dmem_wdata, 32'h7878_7878);
    cyc();
    idle();

    // LH 0x100, sign-extended
    cyc();
    issue(5'd6, 1'b1, WD_MEM, 32'h100, 32'h0, 1'b1, 1'b0, DM_H);
    dmem.dmem_rdata = 32'h0000_8765;
    dmem.dmem_ready = 1'b1;
    expect_out(5'd6, 1'b1, WD_MEM, 32'h100, 32'hFFFF_8765, 1'b0);
    cyc();
    idle();

    // LW 0x101
    cyc();
    issue(5'd3, 1'b1, WD_MEM, 32'h101, 32'h0, 1'b1, 1'b0, DM_W);
    dmem.dmem_rdata = 32'h1122_3344;
    dmem.dmem_ready = 1'b1;
`ifdef MEM_MISALIGN_TRAP_EN
    expect_out(5'd3, 1'b0, WD_MEM, 32'h101, 32'h0, 1'b1);
    @(negedge clk);
    chk("lw_trap_req", {31'h0, dmem.dmem_req}, 32'h0);
    chk("lw_trap_stall", {31'h0, stall_out}, 32'h0);
`else
    expect_out(5'd3, 1'b1, WD_MEM, 32'h101, 32'h1122_3344, 1'b0);
    @(negedge clk);
    chk("lw_align_addr", dmem.dmem_addr, 32'h100);
    chk("lw_align_be", {28'h0, dmem.dmem_be}, 32'hF);
`endif
    cyc();
    idle();

    // back-to-back LHU
    cyc();
    issue(5'd10, 1'b1, WD_MEM, 32'h202, 32'h0, 1'b1, 1'b0, DM_HU);
    dmem.dmem_rdata = 32'h8001_7FFE;
    dmem.dmem_ready = 1'b1;
    expect_out(5'd10, 1'b1, WD_MEM, 32'h202, 32'h0000_8001, 1'b0);
    @(negedge clk);
    chk("b2b_req1", {31'h0, dmem.dmem_req}, 32'h1);
    cyc();
    issue(5'd11, 1'b1, WD_MEM, 32'h200, 32'h0, 1'b1, 1'b0, DM_HU);
    dmem.dmem_rdata = 32'hABCD_F00F;
    dmem.dmem_ready = 1'b1;
    expect_out(5'd11, 1'b1, WD_MEM, 32'h200, 32'h0000_F00F, 1'b0);
    @(negedge clk);
    chk("b2b_valid1", {31'h0, valid_out}, 32'h1);
    chk("b2b_req2", {31'h0, dmem.dmem_req}, 32'h1);
    chk("b2b_addr2", dmem.dmem_addr, 32'h200);
    cyc();
    idle();
    @(negedge clk);
    chk("b2b_valid2", {31'h0, valid_out}, 32'h1);
    cyc();
    @(negedge clk);
    chk("b2b_done", {31'h0, valid_out}, 32'h0);

    // reset during ACCESS
    cyc();
    issue(5'd13, 1'b1, WD_MEM, 32'h300, 32'h0, 1'b1, 1'b0, DM_W);
    cyc();
    #1;
    chk("acc_req", {31'h0, dmem.dmem_req}, 32'h1);
    rstn = 1'b0;
    #1;
    chk("rst_mid_req", {31'h0, dmem.dmem_req}, 32'h0);
    chk("rst_mid_stall", {31'h0, stall_out}, 32'h0);
    chk("rst_mid_valid", {31'h0, valid_out}, 32'h0);
    idle();
    @(negedge clk);
    #2 rstn = 1'b1;
    cyc();
    issue(5'd12, 1'b1, WD_ALU, 32'hCAFE, 32'h0, 1'b0, 1'b0, DM_W);
    expect_out(5'd12, 1'b1, WD_ALU, 32'hCAFE, 32'h0, 1'b0);
    cyc();
    idle();
    @(negedge clk);
    chk("post_rst_alu", {31'h0, valid_out}, 32'h1);

    cyc();
    cyc();
    chk("queue_empty", q.size(), 32'h0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter: ADDR_W, 32, width of dmem_addr (ALU_result low ADDR_W bits).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rstn  in  1  reset, asynchronous, active-low.
REQ-004 valid_in  in  1  EXE-side instruction valid.
REQ-005 ALU_result_in  in  32  effective address or ALU value.
REQ-006 ALU_B_in  in  32  store data (forwarded rs2).
REQ-007 MemRead_in / MemWrite_in  in  1 each  load / store.
REQ-008 DMType_in  in  3  access type: B, H, W, BU, HU.
REQ-009 rd_in  in  5; RegWrite_in  in  1; WDSel_in  in  2: writeback control.
REQ-010 dmem_req, dmem_we  out  1; dmem_addr  out  ADDR_W; dmem_wdata  out  32; dmem_be  out  4.
REQ-011 dmem_rdata  in  32; dmem_ready  in  1: read data / completion.
REQ-012 stall_out  out  1  hold all upstream stages this cycle.
REQ-013 valid_out, rd_out[4:0], RegWrite_out, WDSel_out[1:0], ALU_result_out[31:0], load_data_out[31:0]  out  registered MEM/WB fields.
REQ-014 misalign_exc  out  1  registered misaligned-access flag.

Function
REQ-015 FSM states SHALL be IDLE, ACCESS, RESP.
REQ-016 IDLE, valid_in with no MemRead/MemWrite: SHALL register all pass-through fields next edge (latency 1), stall_out=0.
REQ-017 IDLE, valid_in with MemRead or MemWrite: SHALL assert dmem_req combinationally same cycle, go to ACCESS next edge unless dmem_ready already high (then RESP directly).
REQ-018 ACCESS: dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be SHALL hold stable (latched copies) until dmem_ready=1.
REQ-019 stall_out SHALL be 1 from first request cycle through the cycle dmem_ready is sampled high, else 0.
REQ-020 RESP: valid_out=1 exactly one cycle with captured/extended data; next state IDLE; stall_out=0.
REQ-021 In RESP a new valid_in SHALL be accepted (back-to-back, no bubble).
REQ-022 Stores: dmem_be = 0001<<a[1:0] (B), 0011<<a[1:0] (H), 1111 (W); wdata replicated across lanes.
REQ-023 Loads: lane selected by a[1:0]; B/H sign-extended, BU/HU zero-extended, W unchanged.
REQ-024 Loads with MemRead and MemWrite both set: treated as store; RegWrite_out forced 0.
REQ-025 valid_in=0 in IDLE: valid_out=0, RegWrite_out=0 next edge.
REQ-026 dmem_ready high outside ACCESS/first-request cycle SHALL be ignored.

Reset
REQ-027 rstn low SHALL force IDLE, dmem_req=0, stall_out=0, valid_out=0, RegWrite_out=0, misalign_exc=0, all data outputs 0, immediately and mid-access (outstanding access abandoned).

Configuration
REQ-028 Macro MEM_MISALIGN_TRAP_EN defined: H access with a[0]=1 or W with a[1:0]!=0 SHALL NOT raise dmem_req; next edge valid_out=1, misalign_exc=1, RegWrite_out=0, no stall.
REQ-029 Macro undefined: misalign_exc tied 0; address low bits forced to natural alignment (H: a[0]=0, W: a[1:0]=0) before access.

Structure
REQ-030 Shared package pipe_pkg SHALL hold DMType encodings (B=000, H=001, W=010, BU=011, HU=100), WDSel encodings, FSM state enum.
REQ-031 One sub-module mem_align SHALL do byte-enable generation, store lane replication, load lane select/extend (combinational).

Verification
REQ-032 ALU op, ALU_result_in=0x1234, rd=5 -> next cycle valid_out=1, ALU_result_out=0x1234, rd_out=5, stall_out never 1.
REQ-033 LB addr 0x103, rdata=0x80FF_FF7F, dmem_ready after 3 cycles -> stall_out 3 cycles, load_data_out=0xFFFF_FF80.
REQ-034 SH addr 0x102, ALU_B_in=0x0000_BEEF, ready same cycle -> dmem_be=1100, dmem_wdata=0xBEEF_BEEF, dmem_we=1, RegWrite_out=0.
REQ-035 LW addr 0x101 -> with MEM_MISALIGN_TRAP_EN: no dmem_req, misalign_exc=1; without: dmem_addr=0x100.
REQ-036 rstn low during ACCESS -> dmem_req, stall_out drop immediately; after release, ALU op passes in 1 cycle.
REQ-037 Two back-to-back LHU, ready 1 cycle each -> second accepted in RESP, two valid_out pulses, zero-extended halves.
